// File: rtl/rvc_packer_if.sv
// Handshake bundle for rvc_packer: instruction stream in, packed I-memory words out,
// plus idle/flush control and statistics counters.
interface rvc_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        idle;
  logic [31:0] stat_comp;
  logic [31:0] stat_total;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_word, idle, stat_comp, stat_total
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_word, idle, stat_comp, stat_total
  );
endinterface

// File: rtl/rvc_packer.sv
// RV32I -> RVC re-encoder and little-endian halfword packer for the I-memory loader.
// Optional statistics counters are built when RVC_PACK_STATS_EN is defined.
module rvc_packer #(
  parameter logic [15:0] NOP_PAD = 16'h0001
) (
  input logic         clk,
  input logic         resetb,
  rvc_packer_if.slave bus
);
  typedef enum logic {EMPTY, HALF} state_t;

  state_t      state_reg;
  logic [15:0] pend_reg;
  logic        out_valid_reg;
  logic [31:0] out_word_reg;

  logic [31:0] a;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] i_imm;
  logic [11:0] s_imm;
  logic [20:0] j_imm;
  logic        is_addi, is_add, is_lw, is_sw, is_jal, is_jalr;
  logic        rd_p, rs1_p, rs2_p;
  logic        imm6_ok, lw_off_ok, lwsp_ok, sw_off_ok, swsp_ok, j_ok, link_ok;
  logic        comp;
  logic [15:0] h;
  logic        slot_free;
  logic        accept;

  assign a     = bus.in_instr;
  assign opc   = a[6:0];
  assign f3    = a[14:12];
  assign f7    = a[31:25];
  assign rd    = a[11:7];
  assign rs1   = a[19:15];
  assign rs2   = a[24:20];
  assign i_imm = a[31:20];
  assign s_imm = {a[31:25], a[11:7]};
  assign j_imm = {a[31], a[19:12], a[20], a[30:21], 1'b0};

  assign is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
  assign is_add  = (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0000000);
  assign is_lw   = (opc == 7'b0000011) && (f3 == 3'b010);
  assign is_sw   = (opc == 7'b0100011) && (f3 == 3'b010);
  assign is_jal  = (opc == 7'b1101111);
  assign is_jalr = (opc == 7'b1100111) && (f3 == 3'b000);

  // Compressed register fields only reach x8..x15.
  assign rd_p  = (rd[4:3] == 2'b01);
  assign rs1_p = (rs1[4:3] == 2'b01);
  assign rs2_p = (rs2[4:3] == 2'b01);

  assign imm6_ok   = (i_imm[11:5] == {7{i_imm[5]}});
  assign lw_off_ok = (i_imm[11:7] == 5'd0) && (i_imm[1:0] == 2'b00);
  assign lwsp_ok   = (i_imm[11:8] == 4'd0) && (i_imm[1:0] == 2'b00);
  assign sw_off_ok = (s_imm[11:7] == 5'd0) && (s_imm[1:0] == 2'b00);
  assign swsp_ok   = (s_imm[11:8] == 4'd0) && (s_imm[1:0] == 2'b00);
  assign j_ok      = (j_imm[20:11] == {10{j_imm[11]}});
  assign link_ok   = (rd[4:1] == 4'd0);

  always_comb begin
    comp = 1'b1;
    h    = 16'h0000;
    if (a == 32'h0000_0013)
      h = 16'h0001;
    else if (is_addi && rs1 == 5'd0 && rd != 5'd0 && imm6_ok)
      h = {3'b010, i_imm[5], rd, i_imm[4:0], 2'b01};
    else if (is_addi && rs1 == rd && rd != 5'd0 && i_imm != 12'd0 && imm6_ok)
      h = {3'b000, i_imm[5], rd, i_imm[4:0], 2'b01};
    else if (is_add && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0)
      h = {4'b1000, rd, rs2, 2'b10};
    else if (is_add && rs1 == rd && rd != 5'd0 && rs2 != 5'd0)
      h = {4'b1001, rd, rs2, 2'b10};
    else if (is_lw && rd_p && rs1_p && lw_off_ok)
      h = {3'b010, i_imm[5:3], rs1[2:0], i_imm[2], i_imm[6], rd[2:0], 2'b00};
    else if (is_sw && rs2_p && rs1_p && sw_off_ok)
      h = {3'b110, s_imm[5:3], rs1[2:0], s_imm[2], s_imm[6], rs2[2:0], 2'b00};
    else if (is_lw && rs1 == 5'd2 && rd != 5'd0 && lwsp_ok)
      h = {3'b010, i_imm[5], rd, i_imm[4:2], i_imm[7:6], 2'b10};
    else if (is_sw && rs1 == 5'd2 && swsp_ok)
      h = {3'b110, s_imm[5:2], s_imm[7:6], rs2, 2'b10};
    else if (is_jal && link_ok && j_ok)
      h = {rd[0] ? 3'b001 : 3'b101, j_imm[11], j_imm[4], j_imm[9:8], j_imm[10],
           j_imm[6], j_imm[7], j_imm[3:1], j_imm[5], 2'b01};
    else if (is_jalr && link_ok && rs1 != 5'd0 && i_imm == 12'd0)
      h = {3'b100, rd[0], rs1, 5'd0, 2'b10};
    else if (a == 32'h0010_0073)
      h = 16'h9002;
    else
      comp = 1'b0;
  end

  // Flush shares the slot with input, so it is simply kept out of the accept path.
  assign slot_free     = !out_valid_reg || bus.out_ready;
  assign bus.in_ready  = !bus.flush && slot_free;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_word  = out_word_reg;
  assign bus.idle      = (state_reg == EMPTY) && !out_valid_reg;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_reg     <= EMPTY;
      pend_reg      <= 16'h0000;
      out_valid_reg <= 1'b0;
      out_word_reg  <= 32'h0000_0000;
    end else begin
      if (out_valid_reg && bus.out_ready)
        out_valid_reg <= 1'b0;
      if (accept) begin
        case (state_reg)
          EMPTY: begin
            if (comp) begin
              pend_reg  <= h;
              state_reg <= HALF;
            end else begin
              out_word_reg  <= a;
              out_valid_reg <= 1'b1;
            end
          end
          HALF: begin
            out_valid_reg <= 1'b1;
            if (comp) begin
              out_word_reg <= {h, pend_reg};
              state_reg    <= EMPTY;
            end else begin
              out_word_reg <= {a[15:0], pend_reg};
              pend_reg     <= a[31:16];
            end
          end
          default: state_reg <= EMPTY;
        endcase
      end else if (bus.flush && state_reg == HALF && slot_free) begin
        out_word_reg  <= {NOP_PAD, pend_reg};
        out_valid_reg <= 1'b1;
        state_reg     <= EMPTY;
      end
    end
  end

`ifdef RVC_PACK_STATS_EN
  logic [31:0] stat_comp_reg;
  logic [31:0] stat_total_reg;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      stat_comp_reg  <= 32'd0;
      stat_total_reg <= 32'd0;
    end else if (accept) begin
      stat_total_reg <= stat_total_reg + 32'd1;
      if (comp)
        stat_comp_reg <= stat_comp_reg + 32'd1;
    end
  end

  assign bus.stat_comp  = stat_comp_reg;
  assign bus.stat_total = stat_total_reg;
`else
  assign bus.stat_comp  = 32'd0;
  assign bus.stat_total = 32'd0;
`endif
endmodule

// File: tb/tb_rvc_packer.sv
// Bench for rvc_packer: directed cases plus a random stream whose output halfwords are
// expanded by an independent RVC decoder and compared with the accepted instructions.
module tb_rvc_packer;
  logic clk = 1'b0;
  logic resetb = 1'b0;
  rvc_packer_if bus();

  rvc_packer dut (.clk(clk), .resetb(resetb), .bus(bus));

  always #5 clk = ~clk;

`ifdef RVC_PACK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    int          kind;   // 0 verbatim word, 1 compressed halfword, 2 flush pad
  } item_t;

  item_t       items[$];
  logic [15:0] hw_q[$];
  logic [31:0] wq[$];
  bit          half_pending = 1'b0;
  int unsigned acc_total = 0;
  int unsigned acc_comp = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input int unsigned v);
    return STATS ? v : 32'd0;
  endfunction

  function automatic bit creg(input int r);
    return r >= 8 && r <= 15;
  endfunction

  // Compressibility decided from the architectural rules on decoded integer fields.
  function automatic bit model_comp(input logic [31:0] a);
    int rd, rs1, rs2, iimm, simm, jimm;
    rd   = int'(a[11:7]);
    rs1  = int'(a[19:15]);
    rs2  = int'(a[24:20]);
    iimm = int'({{20{a[31]}}, a[31:20]});
    simm = int'({{20{a[31]}}, a[31:25], a[11:7]});
    jimm = int'({{11{a[31]}}, a[31], a[19:12], a[20], a[30:21], 1'b0});
    if (a == 32'h0000_0013 || a == 32'h0010_0073) return 1'b1;
    if (a[6:0] == 7'h13 && a[14:12] == 3'd0 && rd != 0 && iimm >= -32 && iimm <= 31 &&
        (rs1 == 0 || (rs1 == rd && iimm != 0))) return 1'b1;
    if (a[6:0] == 7'h33 && a[14:12] == 3'd0 && a[31:25] == 7'd0 && rd != 0 && rs2 != 0 &&
        (rs1 == 0 || rs1 == rd)) return 1'b1;
    if (a[6:0] == 7'h03 && a[14:12] == 3'd2 && iimm % 4 == 0) begin
      if (creg(rd) && creg(rs1) && iimm >= 0 && iimm <= 124) return 1'b1;
      if (rs1 == 2 && rd != 0 && iimm >= 0 && iimm <= 252) return 1'b1;
    end
    if (a[6:0] == 7'h23 && a[14:12] == 3'd2 && simm % 4 == 0) begin
      if (creg(rs2) && creg(rs1) && simm >= 0 && simm <= 124) return 1'b1;
      if (rs1 == 2 && simm >= 0 && simm <= 252) return 1'b1;
    end
    if (a[6:0] == 7'h6f && rd <= 1 && jimm >= -2048 && jimm <= 2046) return 1'b1;
    if (a[6:0] == 7'h67 && a[14:12] == 3'd0 && rd <= 1 && rs1 != 0 && iimm == 0) return 1'b1;
    return 1'b0;
  endfunction

  // Core-style RVC expansion; bit 32 set means illegal/not an expected encoding.
  function automatic logic [32:0] decomp(input logic [15:0] h);
    logic [4:0]  rd, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [20:0] j;
    rd  = h[11:7];
    rs2 = h[6:2];
    f3  = h[15:13];
    decomp = {1'b1, 32'h0};
    case (h[1:0])
      2'b00: begin
        imm = {5'b0, h[5], h[12:10], h[6], 2'b00};
        if (f3 == 3'b010)
          decomp = {1'b0, imm, 2'b01, h[9:7], 3'b010, 2'b01, h[4:2], 7'b0000011};
        else if (f3 == 3'b110)
          decomp = {1'b0, imm[11:5], 2'b01, h[4:2], 2'b01, h[9:7], 3'b010, imm[4:0], 7'b0100011};
      end
      2'b01: begin
        imm = {{7{h[12]}}, h[6:2]};
        j   = {{10{h[12]}}, h[8], h[10:9], h[6], h[7], h[2], h[11], h[5:3], 1'b0};
        case (f3)
          3'b000: if ((rd == 5'd0) == (imm == 12'd0))
                    decomp = {1'b0, imm, rd, 3'b000, rd, 7'b0010011};
          3'b001: decomp = {1'b0, j[20], j[10:1], j[11], j[19:12], 5'd1, 7'b1101111};
          3'b010: if (rd != 5'd0) decomp = {1'b0, imm, 5'd0, 3'b000, rd, 7'b0010011};
          3'b101: decomp = {1'b0, j[20], j[10:1], j[11], j[19:12], 5'd0, 7'b1101111};
          default: ;
        endcase
      end
      2'b10: begin
        case (f3)
          3'b010: if (rd != 5'd0)
                    decomp = {1'b0, 4'b0, h[3:2], h[12], h[6:4], 2'b00, 5'd2, 3'b010, rd, 7'b0000011};
          3'b100: begin
            if (!h[12]) begin
              if (rs2 == 5'd0) begin
                if (rd != 5'd0) decomp = {1'b0, 12'd0, rd, 3'b000, 5'd0, 7'b1100111};
              end else if (rd != 5'd0)
                decomp = {1'b0, 7'd0, rs2, 5'd0, 3'b000, rd, 7'b0110011};
            end else begin
              if (rd == 5'd0 && rs2 == 5'd0) decomp = {1'b0, 32'h0010_0073};
              else if (rs2 == 5'd0) decomp = {1'b0, 12'd0, rd, 3'b000, 5'd1, 7'b1100111};
              else if (rd != 5'd0) decomp = {1'b0, 7'd0, rs2, rd, 3'b000, rd, 7'b0110011};
            end
          end
          3'b110: begin
            imm = {4'b0, h[8:7], h[12:9], 2'b00};
            decomp = {1'b0, imm[11:5], rs2, 5'd2, 3'b010, imm[4:0], 7'b0100011};
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    logic [31:0] t, r1, d, f;
    t = imm; r1 = rs1; d = rd; f = f3;
    return {t[11:0], r1[4:0], f[2:0], d[4:0], op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] t, r1, r2;
    t = imm; r1 = rs1; r2 = rs2;
    return {t[11:5], r2[4:0], r1[4:0], 3'b010, t[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
    logic [31:0] d, r1, r2;
    d = rd; r1 = rs1; r2 = rs2;
    return {7'd0, r2[4:0], r1[4:0], 3'b000, d[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] t, d;
    t = imm; d = rd;
    return {t[20], t[10:1], t[11], t[19:12], d[4:0], 7'b1101111};
  endfunction

  function automatic int pick_reg(input int same);
    case ($urandom_range(0, 3))
      0: return 0;
      1: return same;
      2: return 8 + int'($urandom_range(0, 7));
      default: return int'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    int rd, rs1, off;
    rd = int'($urandom_range(0, 31));
    case ($urandom_range(0, 8))
      0: begin
        rs1 = pick_reg(rd);
        off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 80)) - 40;
        return enc_i(off, rs1, 0, rd, 7'h13);
      end
      1: return enc_add(rd, pick_reg(rd), pick_reg(rd));
      2: begin
        rs1 = ($urandom_range(0, 1) == 0) ? 2 : pick_reg(rd);
        off = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 300)) - 20 : 4 * int'($urandom_range(0, 70));
        return enc_i(off, rs1, 2, pick_reg(rd), 7'h03);
      end
      3: begin
        rs1 = ($urandom_range(0, 1) == 0) ? 2 : pick_reg(rd);
        off = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 300)) - 20 : 4 * int'($urandom_range(0, 70));
        return enc_s(off, pick_reg(rd), rs1);
      end
      4: return enc_j(2 * (int'($urandom_range(0, 2200)) - 1100), int'($urandom_range(0, 2)));
      5: return enc_i(($urandom_range(0, 3) == 0) ? 4 : 0, pick_reg(rd), 0, int'($urandom_range(0, 2)), 7'h67);
      6: return ($urandom_range(0, 1) == 0) ? 32'h0010_0073 : 32'h0000_0013;
      7: return $urandom | 32'h3;
      default: return {$urandom_range(0, 32'hFFFFF), rd[4:0], 7'b0110111};
    endcase
  endfunction

  task automatic model_accept(input logic [31:0] instr);
    item_t it;
    it.instr = instr;
    it.kind  = model_comp(instr) ? 1 : 0;
    items.push_back(it);
    acc_total++;
    if (it.kind == 1) begin
      acc_comp++;
      half_pending = !half_pending;
    end
  endtask

  task automatic model_reset();
    items.delete();
    hw_q.delete();
    wq.delete();
    half_pending = 1'b0;
    acc_total = 0;
    acc_comp = 0;
  endtask

  task automatic step(input bit v, input logic [31:0] instr, input bit fl, input bit ordy, output bit got);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
    got = v && bus.in_ready;
    if (got) model_accept(instr);
    if (bus.out_valid && ordy) begin
      wq.push_back(bus.out_word);
      hw_q.push_back(bus.out_word[15:0]);
      hw_q.push_back(bus.out_word[31:16]);
    end
  endtask

  task automatic feed(input logic [31:0] instr, input bit ordy);
    bit got = 1'b0;
    int n = 0;
    while (!got && n < 100) begin
      step(1'b1, instr, 1'b0, ordy, got);
      n++;
    end
    if (!got) check("feed_timeout", 64'd0, 64'd1);
  endtask

  task automatic settle(input int n);
    bit got;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b1, got);
  endtask

  task automatic do_flush(input bit rand_ready);
    bit got;
    int n = 0;
    item_t it;
    if (half_pending) begin
      it.instr = 32'h0;
      it.kind  = 2;
      items.push_back(it);
      half_pending = 1'b0;
    end
    do begin
      step(1'b0, 32'h0, 1'b1, rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1, got);
      n++;
    end while (!bus.idle && n < 200);
    check("flush_idle", bus.idle, 1);
  endtask

  task automatic drain();
    item_t it;
    logic [15:0] lo, hi;
    int need;
    while (items.size() > 0) begin
      need = (items[0].kind == 0) ? 2 : 1;
      if (hw_q.size() < need) break;
      it = items.pop_front();
      lo = hw_q.pop_front();
      case (it.kind)
        0: begin
          hi = hw_q.pop_front();
          check("verbatim", {hi, lo}, it.instr);
        end
        1: check("c_decode", decomp(lo), {1'b0, it.instr});
        default: check("pad", lo, 16'h0001);
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] blist[$];
    bit got;
    int acc, cyc;
    logic [31:0] cur;

    bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    resetb = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_word", bus.out_word, 0);
    check("rst_idle", bus.idle, 1);
    check("rst_stat_total", bus.stat_total, 0);
    @(negedge clk);
    resetb = 1'b1;
    model_reset();

    // two c.addi forms packed into one word
    feed(32'h0014_0413, 1'b1);
    feed(32'hFFF4_8493, 1'b1);
    settle(3);
    check("t1_count", wq.size(), 1);
    check("t1_word", wq[0], 32'h14FD_0405);
    check("t1_stat_comp", bus.stat_comp, exp_stat(acc_comp));
    check("t1_stat_total", bus.stat_total, exp_stat(acc_total));
    drain();
    wq.delete();

    // nop + lui, then flush pads the dangling upper half of the lui
    feed(32'h0000_0013, 1'b1);
    feed(32'h1234_52B7, 1'b1);
    do_flush(1'b0);
    settle(2);
    check("t2_count", wq.size(), 2);
    check("t2_word0", wq[0], 32'h52B7_0001);
    check("t2_word1", wq[1], 32'h0001_1234);
    drain();
    wq.delete();

    // back-pressure holds the word and blocks input
    feed(32'hDEAD_B0B7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hCAFE_1537, 1'b0, 1'b0, got);
      check("t3_in_ready", bus.in_ready, 0);
      check("t3_hold", bus.out_word, 32'hDEAD_B0B7);
    end
    feed(32'hCAFE_1537, 1'b1);
    settle(3);
    check("t3_count", wq.size(), 2);
    check("t3_word0", wq[0], 32'hDEAD_B0B7);
    check("t3_word1", wq[1], 32'hCAFE_1537);
    drain();
    wq.delete();

    // c.lw boundary: offset 8 compresses, 128 does not
    feed(32'h0085_A503, 1'b1);
    feed(32'h0805_A503, 1'b1);
    do_flush(1'b0);
    settle(2);
    check("t4_count", wq.size(), 2);
    check("t4_word0", wq[0], 32'hA503_4588);
    check("t4_word1", wq[1], 32'h0001_0805);
    drain();
    wq.delete();

    // field and offset boundaries, plus a non-32-bit-form word passed verbatim
    blist.push_back(enc_i(-32, 0, 0, 9, 7'h13));   blist.push_back(enc_i(31, 0, 0, 9, 7'h13));
    blist.push_back(enc_i(32, 0, 0, 9, 7'h13));    blist.push_back(enc_i(0, 9, 0, 9, 7'h13));
    blist.push_back(enc_i(1, 0, 0, 0, 7'h13));     blist.push_back(enc_add(5, 0, 6));
    blist.push_back(enc_add(5, 5, 6));             blist.push_back(enc_add(5, 5, 0));
    blist.push_back(enc_i(124, 15, 2, 8, 7'h03));  blist.push_back(enc_i(128, 15, 2, 8, 7'h03));
    blist.push_back(enc_i(2, 15, 2, 8, 7'h03));    blist.push_back(enc_s(124, 9, 8));
    blist.push_back(enc_i(252, 2, 2, 1, 7'h03));   blist.push_back(enc_i(256, 2, 2, 1, 7'h03));
    blist.push_back(enc_i(4, 2, 2, 0, 7'h03));     blist.push_back(enc_s(252, 0, 2));
    blist.push_back(enc_s(256, 3, 2));             blist.push_back(enc_j(2046, 0));
    blist.push_back(enc_j(-2048, 1));              blist.push_back(enc_j(2048, 1));
    blist.push_back(enc_j(8, 5));                  blist.push_back(enc_i(0, 1, 0, 0, 7'h67));
    blist.push_back(enc_i(0, 5, 0, 1, 7'h67));     blist.push_back(enc_i(0, 0, 0, 0, 7'h67));
    blist.push_back(enc_i(4, 1, 0, 0, 7'h67));     blist.push_back(32'h0010_0073);
    blist.push_back(32'h1234_5670);
    foreach (blist[i]) feed(blist[i], 1'b1);
    do_flush(1'b0);
    settle(2);
    drain();
    check("bnd_left", items.size() + hw_q.size(), 0);
    wq.delete();

    // asynchronous reset drops the pending halfword and the held word
    feed(32'h0014_0413, 1'b1);
    feed(32'h1234_52B7, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 resetb = 1'b0;
    #1;
    check("t5_out_valid", bus.out_valid, 0);
    check("t5_idle", bus.idle, 1);
    check("t5_out_word", bus.out_word, 0);
    check("t5_stat_total", bus.stat_total, 0);
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b1, got);
    check("t5_no_pad", wq.size(), 0);
    check("t5_idle_after", bus.idle, 1);
    settle(1);

    // random stream with random stalls and sporadic flushes
    acc = 0;
    cyc = 0;
    cur = rand_instr();
    while (acc < 10000 && cyc < 60000) begin
      if ($urandom_range(0, 299) == 0) do_flush(1'b1);
      step($urandom_range(0, 3) != 0, cur, 1'b0, $urandom_range(0, 3) != 0, got);
      cyc++;
      if (got) begin
        acc++;
        cur = rand_instr();
      end
      if (hw_q.size() > 64) drain();
    end
    check("rand_accepted", acc, 10000);
    do_flush(1'b1);
    settle(2);
    drain();
    check("rand_items_left", items.size(), 0);
    check("rand_hw_left", hw_q.size(), 0);
    check("rand_stat_comp", bus.stat_comp, exp_stat(acc_comp));
    check("rand_stat_total", bus.stat_total, exp_stat(acc_total));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
